// File: rtl/counter_updown_mod.sv
// Parametrised up/down modulo counter with prescaler, wrap/saturate boundary
// handling, a one-cycle terminal pulse and a sticky overflow flag.
module counter_updown_mod #(
  parameter int unsigned WIDTH     = 4,
  parameter int unsigned MAX_VALUE = 2**WIDTH - 1,
  parameter int unsigned PRESCALE  = 1,
  parameter bit          SATURATE  = 1'b0
) (
  input  logic             clock_i,
  input  logic             reset_n_i,
  input  logic             enable_i,
  input  logic             clear_i,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_value_i,
  input  logic             up_down_i,
  output logic [WIDTH-1:0] counter_value_o,
  output logic             terminal_o,
  output logic             overflow_o
);

  localparam logic [WIDTH-1:0] MAX_C = WIDTH'(MAX_VALUE);
  localparam int unsigned      PW    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  generate
    if (WIDTH < 2 || WIDTH > 16) begin : g_bad_width
      $error("counter_updown_mod: WIDTH out of range 2..16");
    end
    if (MAX_VALUE < 1 || MAX_VALUE > 2**WIDTH - 1) begin : g_bad_max
      $error("counter_updown_mod: MAX_VALUE out of range 1..2**WIDTH-1");
    end
    if (PRESCALE < 1 || PRESCALE > 256) begin : g_bad_prescale
      $error("counter_updown_mod: PRESCALE out of range 1..256");
    end
  endgenerate

  logic             step;
  logic [WIDTH-1:0] load_clamped;
  logic [WIDTH-1:0] value_q, value_d;
  logic             term_q, term_d;
  logic             ovf_q, ovf_d;

  // A full-range MAX_VALUE cannot be exceeded, so the clamp disappears.
  generate
    if (MAX_VALUE < 2**WIDTH - 1) begin : g_clamp
      assign load_clamped = (load_value_i > MAX_C) ? MAX_C : load_value_i;
    end else begin : g_no_clamp
      assign load_clamped = load_value_i;
    end
  endgenerate

  generate
    if (PRESCALE > 1) begin : g_pre
      localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE - 1);
      logic [PW-1:0] pre_q, pre_d;

      always_comb begin
        pre_d = pre_q;
        step  = 1'b0;
        if (clear_i || load_i) begin
          pre_d = '0;
        end else if (enable_i) begin
          if (pre_q == PRE_LAST) begin
            pre_d = '0;
            step  = 1'b1;
          end else begin
            pre_d = pre_q + 1'b1;
          end
        end
      end

      always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i) pre_q <= '0;
        else            pre_q <= pre_d;
      end
    end else begin : g_no_pre
      assign step = enable_i & ~clear_i & ~load_i;
    end
  endgenerate

  always_comb begin
    value_d = value_q;
    term_d  = 1'b0;
    ovf_d   = ovf_q;
    if (clear_i) begin
      value_d = '0;
      ovf_d   = 1'b0;
    end else if (load_i) begin
      value_d = load_clamped;
    end else if (step) begin
      if (up_down_i) begin
        if (value_q == MAX_C) begin
          term_d  = 1'b1;
          ovf_d   = 1'b1;
          value_d = SATURATE ? MAX_C : '0;
        end else begin
          value_d = value_q + 1'b1;
        end
      end else begin
        if (value_q == '0) begin
          term_d  = 1'b1;
          ovf_d   = 1'b1;
          value_d = SATURATE ? '0 : MAX_C;
        end else begin
          value_d = value_q - 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      value_q <= '0;
      term_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      value_q <= value_d;
      term_q  <= term_d;
      ovf_q   <= ovf_d;
    end
  end

  assign counter_value_o = value_q;
  assign terminal_o      = term_q;
  assign overflow_o      = ovf_q;

endmodule

// File: tb/tb_counter_updown_mod.sv
// Three counter configurations (wrap, saturate, prescale-by-3) share one stimulus
// stream; a behavioural model feeds a scoreboard queue checked after every edge.
module tb_counter_updown_mod;

  logic       clock = 1'b0;
  logic       reset_n, enable, clear, load, up_down;
  logic [3:0] load_value;
  logic [3:0] val [3];
  logic       term [3];
  logic       ovf  [3];

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  counter_updown_mod #(.WIDTH(4), .MAX_VALUE(9), .PRESCALE(1), .SATURATE(1'b0)) u_wrap (
    .clock_i(clock), .reset_n_i(reset_n), .enable_i(enable), .clear_i(clear),
    .load_i(load), .load_value_i(load_value), .up_down_i(up_down),
    .counter_value_o(val[0]), .terminal_o(term[0]), .overflow_o(ovf[0]));

  counter_updown_mod #(.WIDTH(4), .MAX_VALUE(9), .PRESCALE(1), .SATURATE(1'b1)) u_sat (
    .clock_i(clock), .reset_n_i(reset_n), .enable_i(enable), .clear_i(clear),
    .load_i(load), .load_value_i(load_value), .up_down_i(up_down),
    .counter_value_o(val[1]), .terminal_o(term[1]), .overflow_o(ovf[1]));

  counter_updown_mod #(.WIDTH(4), .MAX_VALUE(9), .PRESCALE(3), .SATURATE(1'b0)) u_pre (
    .clock_i(clock), .reset_n_i(reset_n), .enable_i(enable), .clear_i(clear),
    .load_i(load), .load_value_i(load_value), .up_down_i(up_down),
    .counter_value_o(val[2]), .terminal_o(term[2]), .overflow_o(ovf[2]));

  typedef struct {
    int         idx;
    logic [3:0] v;
    logic       t;
    logic       o;
  } exp_t;

  exp_t sb[$];

  int mv [3];
  int mp [3];
  int mt [3];
  int mo [3];
  int ps  [3] = '{1, 1, 3};
  int sat [3] = '{0, 1, 0};
  localparam int MAXV = 9;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      mv[i] = 0; mp[i] = 0; mt[i] = 0; mo[i] = 0;
    end
  endtask

  task automatic model_edge();
    for (int i = 0; i < 3; i++) begin
      bit st;
      st    = 1'b0;
      mt[i] = 0;
      if (clear) begin
        mv[i] = 0; mp[i] = 0; mo[i] = 0;
      end else if (load) begin
        mv[i] = (int'(load_value) > MAXV) ? MAXV : int'(load_value);
        mp[i] = 0;
      end else if (enable) begin
        if (mp[i] == ps[i] - 1) begin
          mp[i] = 0;
          st    = 1'b1;
        end else begin
          mp[i]++;
        end
      end
      if (st) begin
        if (up_down && mv[i] == MAXV) begin
          mt[i] = 1; mo[i] = 1;
          mv[i] = sat[i] ? MAXV : 0;
        end else if (!up_down && mv[i] == 0) begin
          mt[i] = 1; mo[i] = 1;
          mv[i] = sat[i] ? 0 : MAXV;
        end else begin
          mv[i] = up_down ? mv[i] + 1 : mv[i] - 1;
        end
      end
      sb.push_back('{i, 4'(mv[i]), mt[i][0], mo[i][0]});
    end
  endtask

  // Inputs are already driven; record predictions, clock once, then compare.
  task automatic cycle(input string tag);
    exp_t e;
    model_edge();
    @(posedge clock);
    #1;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      check($sformatf("%s[%0d].value", tag, e.idx), 32'(val[e.idx]), 32'(e.v));
      check($sformatf("%s[%0d].terminal", tag, e.idx), 32'(term[e.idx]), 32'(e.t));
      check($sformatf("%s[%0d].overflow", tag, e.idx), 32'(ovf[e.idx]), 32'(e.o));
    end
  endtask

  task automatic set_in(input logic en, input logic clr, input logic ld,
                        input logic [3:0] lv, input logic up);
    enable = en; clear = clr; load = ld; load_value = lv; up_down = up;
  endtask

  initial begin
    reset_n = 1'b0;
    set_in(1'b0, 1'b0, 1'b0, 4'd0, 1'b1);
    model_reset();
    #12;
    for (int i = 0; i < 3; i++) begin
      check($sformatf("reset[%0d].value", i), 32'(val[i]), 32'd0);
      check($sformatf("reset[%0d].terminal", i), 32'(term[i]), 32'd0);
      check($sformatf("reset[%0d].overflow", i), 32'(ovf[i]), 32'd0);
    end
    @(negedge clock);
    reset_n = 1'b1;

    // Up-count with wrap at 9
    set_in(1'b1, 1'b0, 1'b0, 4'd0, 1'b1);
    for (int k = 0; k < 12; k++) cycle("up");
    check("up_final_wrap", 32'(val[0]), 32'd2);
    check("up_final_sat", 32'(val[1]), 32'd9);

    // Load clamp, then count down through 0
    set_in(1'b0, 1'b0, 1'b1, 4'd15, 1'b0);
    cycle("load15");
    check("load_clamp", 32'(val[0]), 32'd9);
    set_in(1'b1, 1'b0, 1'b0, 4'd0, 1'b0);
    for (int k = 0; k < 11; k++) cycle("down");
    check("down_final", 32'(val[0]), 32'd8);

    // Saturate at top, then reverse
    set_in(1'b0, 1'b0, 1'b1, 4'd8, 1'b1);
    cycle("load8");
    set_in(1'b1, 1'b0, 1'b0, 4'd0, 1'b1);
    for (int k = 0; k < 3; k++) cycle("sat_up");
    check("sat_hold_term", 32'(term[1]), 32'd1);
    up_down = 1'b0;
    cycle("sat_flip");
    check("sat_flip_value", 32'(val[1]), 32'd8);

    // Prescaler with an enable gap
    set_in(1'b0, 1'b1, 1'b0, 4'd0, 1'b1);
    cycle("clear");
    enable = 1'b1; clear = 1'b0;
    for (int k = 0; k < 7; k++) cycle("pre_en");
    check("pre_after7", 32'(val[2]), 32'd2);
    enable = 1'b0;
    for (int k = 0; k < 2; k++) cycle("pre_hold");
    enable = 1'b1;
    for (int k = 0; k < 3; k++) cycle("pre_resume");
    check("pre_resume_value", 32'(val[2]), 32'd3);

    // Clear beats load beats step
    set_in(1'b0, 1'b0, 1'b1, 4'd9, 1'b1);
    cycle("prio_load9");
    enable = 1'b1; load = 1'b0;
    cycle("prio_wrap");
    check("prio_ovf_set", 32'(ovf[0]), 32'd1);
    set_in(1'b1, 1'b1, 1'b1, 4'd5, 1'b1);
    cycle("prio_clear");
    set_in(1'b1, 1'b0, 1'b1, 4'd5, 1'b1);
    cycle("prio_load");
    check("prio_load_nostep", 32'(val[0]), 32'd5);

    // Async reset between edges with prescaler mid-count
    set_in(1'b0, 1'b0, 1'b1, 4'd6, 1'b1);
    cycle("ar_load6");
    set_in(1'b1, 1'b0, 1'b0, 4'd0, 1'b1);
    cycle("ar_step");
    check("ar_pre_value7", 32'(val[0]), 32'd7);
    #2;
    reset_n = 1'b0;
    #1;
    model_reset();
    for (int i = 0; i < 3; i++) begin
      check($sformatf("async[%0d].value", i), 32'(val[i]), 32'd0);
      check($sformatf("async[%0d].terminal", i), 32'(term[i]), 32'd0);
      check($sformatf("async[%0d].overflow", i), 32'(ovf[i]), 32'd0);
    end
    @(negedge clock);
    reset_n = 1'b1;
    for (int k = 0; k < 3; k++) cycle("ar_resume");
    check("ar_full_prescale", 32'(val[2]), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #20000;
    errors++;
    $display("FAIL timeout observed=running expected=finished");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
